sdram_call_arbiter: RTL and testbench
=====================================

# sdram_call_arbiter

Two-requester arbiter for the `graphic_module` SDRAM call port (`iCall`/`oDone`/`iAddr`/`iData`/`oData`). It lets the camera pixel writer and a second requester, such as an overlay or test-pattern writer, share the frame buffer. It sits between those writers and `graphic_module` in the top level, on `CLOCK_MAIN`. Grants are round-robin, one transaction at a time. Command fields are latched at grant, and each transaction has a completion watchdog.

## Interface
- `AW`, default 24: address width; the frame address is {Y[14:0], X[8:0]}.
- `DW`, default 16: data width (RGB565).
- `TIMEOUT`, default 4095: number of cycles to wait for `iDone` before aborting a transaction.

- `clk`  in  1  — `CLOCK_MAIN`; the only clock.
- `rst`  in  1  — synchronous, active-high reset.
- `iCall0`, `iCall1`  in  2 each  — request: [1] write, [0] read. Held high until the matching `oDoneN` pulse.
- `iAddr0`, `iAddr1`  in  AW each  — request address.
- `iData0`, `iData1`  in  DW each  — write data.
- `oDone0`, `oDone1`  out  2 each  — one-cycle completion pulse: [1] write, [0] read.
- `oData0`, `oData1`  out  DW each  — read data; registered, valid from the `oDoneN[0]` pulse until the next read by the same requester.
- `oCall`  out  2  — call to `graphic_module` `iCall`.
- `oAddr`  out  AW  — to `graphic_module` `iAddr`.
- `oWrData`  out  DW  — to `graphic_module` `iData`.
- `iDone`  in  2  — from `graphic_module` `oDone`.
- `iRdData`  in  DW  — from `graphic_module` `oData`.
- `oGrant`  out  2  — one-hot owner of the current transaction; 00 when idle.
- `oTimeout`  out  1  — sticky flag; set on any watchdog abort.

## Operation
- **States:** IDLE, ISSUE, RELEASE.
- **Request decode:** a requester is active when `iCallN != 00`. If both bits are set, the request is treated as a write.
- **IDLE, one requester active:** grant that requester.
- **IDLE, both requesters active:** grant the requester that is not `last`. `last` is a 1-bit pointer to the most recently granted requester; its reset value is 1, so requester 0 wins the first tie.
- **At grant:**
  - latch the command type, `iAddrN` and `iDataN`;
  - set `oGrant`;
  - clear the watchdog counter;
  - update `last`;
  - go to ISSUE.
- **ISSUE:**
  - `oCall`, `oAddr` and `oWrData` are driven from the latched values and stay stable for the whole state.
  - The watchdog counter increments every cycle.
- **Completion:** `iDone` is complete when `iDone[1]` is high for a write, or `iDone[0]` is high for a read. The non-matching bit is ignored.
- **On completion:**
  - drop `oCall` to 00;
  - pulse the owner's `oDoneN` bit;
  - on a read, capture `iRdData` into `oDataN`;
  - go to RELEASE.
- **Watchdog abort:** when the counter reaches `TIMEOUT` without completion:
  - drop `oCall`;
  - set `oTimeout`;
  - still pulse `oDoneN` so the requester unblocks; `oDataN` is unchanged;
  - go to RELEASE.
- **RELEASE:** lasts one cycle, with `oGrant` = 00. This lets the requester drop `iCall` before it is sampled again; requests are not sampled in this state. Then return to IDLE.
- **Requester drops `iCall` while in ISSUE:** the transaction still completes, and `oDoneN` is still pulsed.
- **Input changes during ISSUE:** changes on `iAddrN` and `iDataN` have no effect.
- **Non-owner requester:** its `oDoneN` stays 00.
- **Watchdog counter:** width is ceil(log2(`TIMEOUT`+1)). The counter saturates and never wraps.

## Timing
- **Reset values:**
  - `oCall` = 00, `oAddr` = 0, `oWrData` = 0;
  - `oDone0` = `oDone1` = 00;
  - `oData0` = `oData1` = 0;
  - `oGrant` = 00, `oTimeout` = 0;
  - state = IDLE, `last` = 1.
- **Reset during ISSUE:** `oCall` is 00 from the next edge and no `oDone` pulse is issued.
- **Cycle sequence** (all outputs are registered):
  - `iCallN` is sampled in IDLE at edge T.
  - `oCall` and `oGrant` are valid after T (cycle T+1).
  - `iDone` is sampled high at edge M.
  - After M: `oDoneN` pulse, `oCall` = 00, RELEASE.
  - After M+1: IDLE.
  - The earliest next `oCall` is valid after M+2.
- **Minimum overhead:** 3 cycles per transaction on top of `graphic_module` latency.
- **Done pulse width:** exactly 1 cycle.
- **Watchdog:** the abort `oDoneN` pulse occurs on the cycle after the counter reaches `TIMEOUT`.

## Test plan
- **Reset values:** reset asserted for 3 cycles -> every output at its reset value. Then `iCall0` = 10, `iAddr0` = 0x000005, `iData0` = 0xF800 -> `oCall` = 10, `oAddr` = 0x000005, `oWrData` = 0xF800, `oGrant` = 01 on the cycle after sampling.
- **Single write:** model answers `iDone` = 10 after 6 cycles -> `oDone0` = 10 for exactly 1 cycle, `oCall` = 00 on that cycle, next grant possible no earlier than 2 cycles later.
- **Fairness:** both requesters hold write calls continuously -> grants alternate 01, 10, 01, 10 starting with 01; no requester is granted twice in a row.
- **Read path:** `iCall1` = 01 at `iAddr1` = 0x00A0C8; model returns `iRdData` = 0x07E0 with `iDone` = 01 -> `oDone1` = 01 pulse and `oData1` = 0x07E0 held afterwards. A spurious `iDone` = 10 during the read is ignored.
- **Watchdog:** `TIMEOUT` = 15 and the model never answers -> `oCall` drops, `oDone0` pulses and `oTimeout` = 1 sticky, all on the cycle after the counter reaches 15. `oData0` is unchanged.
- **Reset mid-transaction and input stability:** `rst` asserted while in ISSUE -> `oCall` = 00 and `oGrant` = 00 next cycle, no `oDone` pulse. Changing `iAddr0` mid-ISSUE -> `oAddr` unchanged.

Source files
------------

// File: rtl/sdram_call_arbiter.sv
// rtl/sdram_call_arbiter.sv - round-robin two-requester arbiter for the graphic_module SDRAM call port
// One transaction at a time; command fields latched at grant, completion guarded by a saturating watchdog.
module sdram_call_arbiter #(
  parameter int AW      = 24,
  parameter int DW      = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    iCall0,
  input  logic [1:0]    iCall1,
  input  logic [AW-1:0] iAddr0,
  input  logic [AW-1:0] iAddr1,
  input  logic [DW-1:0] iData0,
  input  logic [DW-1:0] iData1,
  output logic [1:0]    oDone0,
  output logic [1:0]    oDone1,
  output logic [DW-1:0] oData0,
  output logic [DW-1:0] oData1,
  output logic [1:0]    oCall,
  output logic [AW-1:0] oAddr,
  output logic [DW-1:0] oWrData,
  input  logic [1:0]    iDone,
  input  logic [DW-1:0] iRdData,
  output logic [1:0]    oGrant,
  output logic          oTimeout
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    call_q, call_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    done0_q, done0_d;
  logic [1:0]    done1_q, done1_d;
  logic [DW-1:0] data0_q, data0_d;
  logic [DW-1:0] data1_q, data1_d;
  logic          timeout_q, timeout_d;

  logic       act0, act1, sel, complete;
  logic [1:0] sel_call;

  // On a tie the requester that was not granted last wins.
  assign act0     = |iCall0;
  assign act1     = |iCall1;
  assign sel      = (act0 && act1) ? ~last_q : act1;
  assign sel_call = sel ? iCall1 : iCall0;
  assign complete = wr_q ? iDone[1] : iDone[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      call_q    <= 2'b00;
      grant_q   <= 2'b00;
      done0_q   <= 2'b00;
      done1_q   <= 2'b00;
      data0_q   <= '0;
      data1_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      call_q    <= call_d;
      grant_q   <= grant_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    call_d    = call_q;
    grant_d   = grant_q;
    done0_d   = 2'b00;
    done1_d   = 2'b00;
    data0_d   = data0_q;
    data1_d   = data1_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (act0 || act1) begin
          owner_d = sel;
          last_d  = sel;
          wr_d    = sel_call[1];
          addr_d  = sel ? iAddr1 : iAddr0;
          wdata_d = sel ? iData1 : iData0;
          cnt_d   = '0;
          call_d  = sel_call[1] ? 2'b10 : 2'b01;
          grant_d = sel ? 2'b10 : 2'b01;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A late iDone on the timeout cycle still counts as a normal completion.
        if (complete || (cnt_q == CNT_MAX)) begin
          call_d  = 2'b00;
          grant_d = 2'b00;
          state_d = RELEASE;
          if (owner_q) done1_d = wr_q ? 2'b10 : 2'b01;
          else         done0_d = wr_q ? 2'b10 : 2'b01;
          if (!complete) timeout_d = 1'b1;
          else if (!wr_q) begin
            if (owner_q) data1_d = iRdData;
            else         data0_d = iRdData;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign oCall    = call_q;
  assign oAddr    = addr_q;
  assign oWrData  = wdata_q;
  assign oGrant   = grant_q;
  assign oDone0   = done0_q;
  assign oDone1   = done1_q;
  assign oData0   = data0_q;
  assign oData1   = data1_q;
  assign oTimeout = timeout_q;

endmodule

// File: tb/tb_sdram_call_arbiter.sv
// tb/tb_sdram_call_arbiter.sv - directed bench for sdram_call_arbiter with TIMEOUT = 15
module tb_sdram_call_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  iCall0, iCall1, iDone;
  logic [23:0] iAddr0, iAddr1;
  logic [15:0] iData0, iData1, iRdData;
  logic [1:0]  oDone0, oDone1, oCall, oGrant;
  logic [15:0] oData0, oData1, oWrData;
  logic [23:0] oAddr;
  logic        oTimeout;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_call_arbiter #(.AW(24), .DW(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .iCall0(iCall0), .iCall1(iCall1),
    .iAddr0(iAddr0), .iAddr1(iAddr1),
    .iData0(iData0), .iData1(iData1),
    .oDone0(oDone0), .oDone1(oDone1),
    .oData0(oData0), .oData1(oData1),
    .oCall(oCall), .oAddr(oAddr), .oWrData(oWrData),
    .iDone(iDone), .iRdData(iRdData),
    .oGrant(oGrant), .oTimeout(oTimeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  c0;
    logic [23:0] a0;
    logic [15:0] d0;
    logic [1:0]  idone;
    logic [1:0]  e_call;
    logic [1:0]  e_grant;
    logic [1:0]  e_done0;
    logic [23:0] e_addr;
    logic [15:0] e_wdata;
  } vec_t;

  vec_t tbl[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iCall0 = 2'b00; iCall1 = 2'b00; iDone = 2'b00;
    iAddr0 = '0; iAddr1 = '0; iData0 = '0; iData1 = '0; iRdData = '0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b10, 24'h000005, 16'hF800, 2'b00, 2'b10, 2'b01, 2'b00, 24'h000005, 16'hF800};
    tbl[1]  = '{2'b10, 24'h000005, 16'hF800, 2'b00, 2'b10, 2'b01, 2'b00, 24'h000005, 16'hF800};
    tbl[2]  = '{2'b10, 24'h000005, 16'hF800, 2'b00, 2'b10, 2'b01, 2'b00, 24'h000005, 16'hF800};
    tbl[3]  = '{2'b10, 24'h000777, 16'h1234, 2'b00, 2'b10, 2'b01, 2'b00, 24'h000005, 16'hF800};
    tbl[4]  = '{2'b10, 24'h000777, 16'h1234, 2'b00, 2'b10, 2'b01, 2'b00, 24'h000005, 16'hF800};
    tbl[5]  = '{2'b10, 24'h000777, 16'h1234, 2'b01, 2'b10, 2'b01, 2'b00, 24'h000005, 16'hF800};
    tbl[6]  = '{2'b10, 24'h000777, 16'h1234, 2'b10, 2'b00, 2'b00, 2'b10, 24'h000005, 16'hF800};
    tbl[7]  = '{2'b10, 24'h000123, 16'h0ABC, 2'b00, 2'b00, 2'b00, 2'b00, 24'h000005, 16'hF800};
    tbl[8]  = '{2'b10, 24'h000123, 16'h0ABC, 2'b00, 2'b10, 2'b01, 2'b00, 24'h000123, 16'h0ABC};
    tbl[9]  = '{2'b10, 24'h000123, 16'h0ABC, 2'b10, 2'b00, 2'b00, 2'b10, 24'h000123, 16'h0ABC};
    tbl[10] = '{2'b00, 24'h000123, 16'h0ABC, 2'b00, 2'b00, 2'b00, 2'b00, 24'h000123, 16'h0ABC};
    tbl[11] = '{2'b00, 24'h000123, 16'h0ABC, 2'b00, 2'b00, 2'b00, 2'b00, 24'h000123, 16'h0ABC};

    // Reset values
    do_reset();
    check("rst_oCall", oCall, 0);
    check("rst_oAddr", oAddr, 0);
    check("rst_oWrData", oWrData, 0);
    check("rst_oDone0", oDone0, 0);
    check("rst_oDone1", oDone1, 0);
    check("rst_oData0", oData0, 0);
    check("rst_oData1", oData1, 0);
    check("rst_oGrant", oGrant, 0);
    check("rst_oTimeout", oTimeout, 0);

    // Single write, input stability in ISSUE, RELEASE gap, back-to-back request
    for (int i = 0; i < 12; i++) begin
      iCall0 = tbl[i].c0; iAddr0 = tbl[i].a0; iData0 = tbl[i].d0; iDone = tbl[i].idone;
      step();
      check($sformatf("tbl%0d_oCall", i), oCall, tbl[i].e_call);
      check($sformatf("tbl%0d_oGrant", i), oGrant, tbl[i].e_grant);
      check($sformatf("tbl%0d_oDone0", i), oDone0, tbl[i].e_done0);
      check($sformatf("tbl%0d_oDone1", i), oDone1, 0);
      check($sformatf("tbl%0d_oAddr", i), oAddr, tbl[i].e_addr);
      check($sformatf("tbl%0d_oWrData", i), oWrData, tbl[i].e_wdata);
    end

    // Fairness: both requesters hold write calls continuously
    do_reset();
    iCall0 = 2'b10; iAddr0 = 24'h000010; iData0 = 16'h1111;
    iCall1 = 2'b10; iAddr1 = 24'h000020; iData1 = 16'h2222;
    for (int t = 0; t < 4; t++) begin
      int k;
      logic [1:0] exp_g;
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      k = 0;
      step();
      while (oGrant == 2'b00 && k < 10) begin
        step();
        k++;
      end
      check($sformatf("fair%0d_grant", t), oGrant, exp_g);
      check($sformatf("fair%0d_addr", t), oAddr, (t % 2 == 0) ? 24'h000010 : 24'h000020);
      step();
      iDone = 2'b10;
      step();
      iDone = 2'b00;
      check($sformatf("fair%0d_done0", t), oDone0, (t % 2 == 0) ? 2'b10 : 2'b00);
      check($sformatf("fair%0d_done1", t), oDone1, (t % 2 == 0) ? 2'b00 : 2'b10);
      check($sformatf("fair%0d_call_drop", t), oCall, 0);
    end
    iCall0 = 2'b00; iCall1 = 2'b00;

    // Read path with a spurious write-done
    do_reset();
    iCall1 = 2'b01; iAddr1 = 24'h00A0C8;
    step();
    check("rd_oCall", oCall, 2'b01);
    check("rd_oGrant", oGrant, 2'b10);
    check("rd_oAddr", oAddr, 24'h00A0C8);
    iDone = 2'b10; iRdData = 16'h1111;
    step();
    check("rd_spurious_call", oCall, 2'b01);
    check("rd_spurious_done1", oDone1, 0);
    iDone = 2'b00;
    step();
    iDone = 2'b01; iRdData = 16'h07E0;
    step();
    check("rd_done1", oDone1, 2'b01);
    check("rd_done0", oDone0, 0);
    check("rd_call_drop", oCall, 0);
    check("rd_data1", oData1, 16'h07E0);
    iCall1 = 2'b00; iDone = 2'b00; iRdData = 16'hDEAD;
    step();
    check("rd_done1_width", oDone1, 0);
    repeat (2) step();
    check("rd_data1_held", oData1, 16'h07E0);
    check("rd_data0_untouched", oData0, 0);

    // Watchdog abort; a read-done during a write and stray read data are ignored
    iCall0 = 2'b10; iAddr0 = 24'h000042; iData0 = 16'h5555;
    step();
    check("wd_grant", oGrant, 2'b01);
    iDone = 2'b01; iRdData = 16'hBEEF;
    for (int j = 1; j <= 15; j++) begin
      step();
      check($sformatf("wd_call_%0d", j), oCall, 2'b10);
    end
    check("wd_timeout_early", oTimeout, 0);
    check("wd_done0_early", oDone0, 0);
    step();
    check("wd_call_drop", oCall, 0);
    check("wd_done0", oDone0, 2'b10);
    check("wd_timeout", oTimeout, 1);
    check("wd_data0", oData0, 0);
    check("wd_done1", oDone1, 0);
    iCall0 = 2'b00; iDone = 2'b00;
    repeat (3) step();
    check("wd_timeout_sticky", oTimeout, 1);
    check("wd_done0_quiet", oDone0, 0);

    // Reset during ISSUE and address stability
    iCall0 = 2'b10; iAddr0 = 24'h000055;
    step();
    check("mr_grant", oGrant, 2'b01);
    iAddr0 = 24'h000099;
    step();
    check("mr_addr_stable", oAddr, 24'h000055);
    rst = 1'b1;
    step();
    check("mr_call", oCall, 0);
    check("mr_grant_clr", oGrant, 0);
    check("mr_done0", oDone0, 0);
    check("mr_timeout_clr", oTimeout, 0);
    rst = 1'b0; iCall0 = 2'b00; iDone = 2'b10;
    step();
    check("mr_no_done", oDone0, 0);
    check("mr_idle_call", oCall, 0);
    iDone = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
